wait_time_bcd_display: RTL and testbench

Parametrised, clocked successor to the counter-side waiting-time readout. It converts a WIDTH-bit binary waiting time to DIGITS BCD digits with a sequential shift-add-3 (double-dabble) engine. It then drives a time-multiplexed common-segment display with leading-zero blanking and overflow saturation. It sits between the queue's waiting-time estimator and the front-panel 7-segment bank.

---
 rtl/wtd_pkg.sv | 20 ++
 rtl/bcd_7_seg.sv | 23 ++
 rtl/wait_time_bcd_display.sv | 143 ++++++++++++++
 tb/tb_wait_time_bcd_display.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wtd_pkg.sv
// Shared types and elaboration-time helpers for the waiting-time BCD display.
package wtd_pkg;

  typedef enum logic {IDLE = 1'b0, CONV = 1'b1} state_e;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Decimal digits needed for 2^width-1: ceil(width*log10(2)) in integer math.
  function automatic int bcd_digits_for(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_7_seg.sv
// BCD digit to 7-segment decoder, seg[6]=a .. seg[0]=g, active-high.
module bcd_7_seg (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    unique case (i_bcd)
      4'd0:    o_seg = 7'b1111110;
      4'd1:    o_seg = 7'b0110000;
      4'd2:    o_seg = 7'b1101101;
      4'd3:    o_seg = 7'b1111001;
      4'd4:    o_seg = 7'b0110011;
      4'd5:    o_seg = 7'b1011011;
      4'd6:    o_seg = 7'b1011111;
      4'd7:    o_seg = 7'b1110000;
      4'd8:    o_seg = 7'b1111111;
      4'd9:    o_seg = 7'b1111011;
      default: o_seg = 7'b0000000;
    endcase
  end

endmodule

// File: rtl/wait_time_bcd_display.sv
// Sequential double-dabble conversion of a binary waiting time, feeding a
// scanned 7-segment bank with leading-zero blanking and overflow saturation.
module wait_time_bcd_display
  import wtd_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [WIDTH-1:0]      i_wtime,
  input  logic                  i_load,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic                  o_overflow,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [6:0]            o_seg,
  output logic [DIGITS-1:0]     o_an
);

  localparam int SD   = bcd_digits_for(WIDTH);
  localparam int XD   = (SD > DIGITS) ? SD : DIGITS;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW   = $clog2(DIGITS);
  localparam int MAXV = pow10(DIGITS) - 1;

  state_e            r_state;
  logic [WIDTH-1:0]  r_bin;
  logic [4*SD-1:0]   r_scr;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf;

  logic [4*SD-1:0]   w_adj;
  logic [4*SD-1:0]   w_scr_nxt;
  logic [4*XD-1:0]   w_scr_ext;
  logic              w_ovf_in;

  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < SD; i++)
      if (r_scr[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
  end

  assign w_scr_nxt = {w_adj[4*SD-2:0], r_bin[WIDTH-1]};
  // Zero-extend so DIGITS may exceed the digits the scratch register needs.
  assign w_scr_ext = (4*XD)'(w_scr_nxt);
  assign w_ovf_in  = 32'(i_wtime) > MAXV;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
      o_bcd      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_bin   <= i_wtime;
            r_scr   <= '0;
            r_cnt   <= '0;
            r_ovf   <= w_ovf_in;
            o_valid <= 1'b0;
            o_busy  <= 1'b1;
            r_state <= CONV;
          end
        end
        CONV: begin
          r_scr <= w_scr_nxt;
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
          // Final iteration: publish bcd/overflow together so the display never sees partials.
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state    <= IDLE;
            o_busy     <= 1'b0;
            o_valid    <= 1'b1;
            o_overflow <= r_ovf;
            o_bcd      <= r_ovf ? {DIGITS{4'h9}} : w_scr_ext[4*DIGITS-1:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic [PW-1:0]     r_presc;
  logic [IW-1:0]     r_idx;
  logic [3:0]        w_dig;
  logic [6:0]        w_dec;
  logic [DIGITS-1:0] w_lz;
  logic              w_allz;
  logic              w_blank;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (r_presc == PW'(SCAN_DIV - 1)) begin
      r_presc <= '0;
      r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_dig = o_bcd[4*r_idx +: 4];

  bcd_7_seg u_dec (
    .i_bcd (w_dig),
    .o_seg (w_dec)
  );

  // w_lz[i]: digit i and everything above it are zero (digit 0 never qualifies).
  always_comb begin
    w_lz   = '0;
    w_allz = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_allz  = w_allz & (o_bcd[4*i +: 4] == 4'd0);
      w_lz[i] = w_allz;
    end
  end

  assign w_blank = (BLANK_LZ != 0) && !o_overflow && w_lz[r_idx];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_an  <= DIGITS'(1);
      o_seg <= 7'b1111110;
    end else begin
      o_an  <= DIGITS'(1) << r_idx;
      o_seg <= w_blank ? SEG_BLANK : w_dec;
    end
  end

endmodule

// File: tb/tb_wait_time_bcd_display.sv
// Scoreboarded bench: three instances (8b blanking, 8b no blanking, 10b fast scan).
module tb_wait_time_bcd_display;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst, ld;
  logic [7:0]       wt0, wt1;
  logic [9:0]       wt2;
  logic [2:0]       busy_o, valid_o, ovf_o;
  logic [2:0][11:0] bcd_o;
  logic [2:0][6:0]  seg_o;
  logic [2:0][2:0]  an_o;
  logic [2:0]       pv = '0;

  int checks = 0;
  int failures = 0;
  exp_t q0[$], q1[$], q2[$];

  wait_time_bcd_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(1)) u_a (
    .i_clk(clk), .i_reset(rst[0]), .i_wtime(wt0), .i_load(ld[0]),
    .o_busy(busy_o[0]), .o_valid(valid_o[0]), .o_overflow(ovf_o[0]),
    .o_bcd(bcd_o[0]), .o_seg(seg_o[0]), .o_an(an_o[0]));

  wait_time_bcd_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(0)) u_b (
    .i_clk(clk), .i_reset(rst[1]), .i_wtime(wt1), .i_load(ld[1]),
    .o_busy(busy_o[1]), .o_valid(valid_o[1]), .o_overflow(ovf_o[1]),
    .o_bcd(bcd_o[1]), .o_seg(seg_o[1]), .o_an(an_o[1]));

  wait_time_bcd_display #(.WIDTH(10), .DIGITS(3), .SCAN_DIV(1), .BLANK_LZ(1)) u_c (
    .i_clk(clk), .i_reset(rst[2]), .i_wtime(wt2), .i_load(ld[2]),
    .o_busy(busy_o[2]), .o_valid(valid_o[2]), .o_overflow(ovf_o[2]),
    .o_bcd(bcd_o[2]), .o_seg(seg_o[2]), .o_an(an_o[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int k);
    exp_t e;
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    return e;
  endfunction

  task automatic qpush(input int k, input logic [11:0] b, input logic o);
    exp_t e;
    e.bcd = b;
    e.ovf = o;
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic set_in(input int k, input logic [9:0] v, input logic l);
    case (k)
      0:       wt0 = v[7:0];
      1:       wt1 = v[7:0];
      default: wt2 = v;
    endcase
    ld[k] = l;
  endtask

  // Monitor: every completed conversion (valid rising) is matched against the queue.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (valid_o[k] && !pv[k]) begin
        checks++;
        if (qsize(k) == 0) begin
          failures++;
          $display("FAIL sb_unexpected[%0d]: got result bcd=%h with nothing expected", k, bcd_o[k]);
        end else begin
          e = qpop(k);
          if (bcd_o[k] !== e.bcd || ovf_o[k] !== e.ovf) begin
            failures++;
            $display("FAIL sb_result[%0d]: got bcd=%h ovf=%b expected bcd=%h ovf=%b",
                     k, bcd_o[k], ovf_o[k], e.bcd, e.ovf);
          end
        end
      end
    end
    pv <= valid_o;
  end

  task automatic conv(input int k, input logic [9:0] v, input logic [11:0] eb,
                      input logic eo, input int w);
    int n;
    qpush(k, eb, eo);
    @(negedge clk);
    set_in(k, v, 1'b1);
    @(negedge clk);
    ld[k] = 1'b0;
    n = 0;
    while (busy_o[k] && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("busy_len[%0d]", k), n, w);
  endtask

  task automatic scan(input int k, input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
    logic [6:0] got [3];
    for (int i = 0; i < 3; i++) got[i] = 'x;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an_o[k])
        3'b001:  got[0] = seg_o[k];
        3'b010:  got[1] = seg_o[k];
        3'b100:  got[2] = seg_o[k];
        default: ;
      endcase
    end
    chk($sformatf("seg_d0[%0d]", k), 32'(got[0]), 32'(s0));
    chk($sformatf("seg_d1[%0d]", k), 32'(got[1]), 32'(s1));
    chk($sformatf("seg_d2[%0d]", k), 32'(got[2]), 32'(s2));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  32'(busy_o[0]),  0);
    chk({tag, "_valid"}, 32'(valid_o[0]), 0);
    chk({tag, "_ovf"},   32'(ovf_o[0]),   0);
    chk({tag, "_bcd"},   32'(bcd_o[0]),   32'h000);
    chk({tag, "_an"},    32'(an_o[0]),    32'b001);
    chk({tag, "_seg"},   32'(seg_o[0]),   32'b1111110);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [2:0] e;
    rst = '1; ld = '0; wt0 = '0; wt1 = '0; wt2 = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst = '0;

    conv(0, 10'd237, 12'h237, 1'b0, 8);
    scan(0, 7'b1110000, 7'b1111001, 7'b1101101);
    conv(0, 10'd5, 12'h005, 1'b0, 8);
    scan(0, 7'b1011011, 7'b0000000, 7'b0000000);
    conv(1, 10'd5, 12'h005, 1'b0, 8);
    scan(1, 7'b1011011, 7'b1111110, 7'b1111110);

    conv(2, 10'd1000, 12'h999, 1'b1, 10);
    chk("ovf_flag", 32'(ovf_o[2]), 1);
    scan(2, 7'b1111011, 7'b1111011, 7'b1111011);
    conv(2, 10'd42, 12'h042, 1'b0, 10);
    chk("ovf_clear", 32'(ovf_o[2]), 0);
    scan(2, 7'b1101101, 7'b0110011, 7'b0000000);
    conv(2, 10'd999, 12'h999, 1'b0, 10);

    // load held through the conversion with wtime wandering: only 123 converts
    qpush(1, 12'h123, 1'b0);
    @(negedge clk);
    set_in(1, 10'd123, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wt1 = 8'(200 + i);
    end
    ld[1] = 1'b0;
    n = 0;
    while (busy_o[1] && n < 40) begin
      n++;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    chk("held_load_busy", 32'(busy_o[1]), 0);
    chk("held_load_valid", 32'(valid_o[1]), 1);

    // scan order and dwell over two full rotations
    n = 0;
    while (an_o[0] === 3'b010 && n < 20) begin n++; @(negedge clk); end
    while (an_o[0] !== 3'b010 && n < 40) begin n++; @(negedge clk); end
    chk("an_sync", 32'(an_o[0]), 32'b010);
    for (int k = 0; k < 24; k++) begin
      e = 3'b001 << ((1 + k / 4) % 3);
      chk("an_seq", 32'(an_o[0]), 32'(e));
      @(negedge clk);
    end

    // reset sampled on the 4th CONV edge aborts the conversion
    @(negedge clk);
    set_in(0, 10'd99, 1'b1);
    @(negedge clk);
    ld[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    chk_reset("abort");
    rst[0] = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_valid", 32'(valid_o[0]), 0);
    chk("abort_bcd", 32'(bcd_o[0]), 32'h000);

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("sb_drained[%0d]", k), qsize(k), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
